// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and receiver FSM state type.
// Used by both the timing generator and the sync receiver.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_FP        = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_FP        = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int VGA_HT       = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_VT       = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  typedef enum logic [1:0] {
    SEARCH,
    H_SEEN,
    V_SEEN,
    LOCKED
  } rx_state_t;

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Registers one active-low sync input and flags its falling and rising edges.
// The sample resets high so an idle-high line never reports an edge at release.
module vga_sync_edge_detect (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_sync_n,
  output logic o_fall,
  output logic o_rise
);

  logic r_sync_q;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync_q <= 1'b1;
    end else begin
      r_sync_q <= i_sync_n;
    end
  end

  assign o_fall = r_sync_q & ~i_sync_n;
  assign o_rise = ~r_sync_q & i_sync_n;

endmodule

// File: rtl/vga_sync_receiver.sv
// Reconstructs pixel coordinates from VGA sync/blank inputs, checks every edge
// against nominal timing and tracks lock plus a saturating locked-error count.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = vga_timing_pkg::VGA_H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::VGA_H_FP,
  parameter int H_SYNC      = vga_timing_pkg::VGA_H_SYNC,
  parameter int H_BP        = vga_timing_pkg::VGA_H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::VGA_V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::VGA_V_FP,
  parameter int V_SYNC      = vga_timing_pkg::VGA_V_SYNC,
  parameter int V_BP        = vga_timing_pkg::VGA_V_BP,
  parameter int LOCK_FRAMES = vga_timing_pkg::VGA_LOCK_FRAMES
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic       blank_n,
  output logic       pixel_valid,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_error,
  output logic [7:0] err_count
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_PREV  = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int         GW       = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  logic [1:0]    w_sync_n;
  logic [1:0]    w_fall;
  logic [1:0]    w_rise;
  logic          w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic [9:0]    r_h_cnt, r_v_cnt;
  logic [9:0]    w_h_est, w_v_est;
  logic          w_err_h, w_err_all, w_err;
  rx_state_t     r_state;
  logic [GW-1:0] r_good;
  logic          r_locked, r_timing_error, r_pixel_valid, r_frame_start;
  logic [7:0]    r_err_count;
  logic [9:0]    r_pixel_x, r_pixel_y;

  // Index 0 is hsync, index 1 is vsync.
  assign w_sync_n = {vsync_n, hsync_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    vga_sync_edge_detect u_edge (
      .i_clk    (vga_clk),
      .i_srst   (reset),
      .i_sync_n (w_sync_n[gi]),
      .o_fall   (w_fall[gi]),
      .o_rise   (w_rise[gi])
    );
  end

  assign w_hs_fall = w_fall[0];
  assign w_hs_rise = w_rise[0];
  assign w_vs_fall = w_fall[1];
  assign w_vs_rise = w_rise[1];

  // Sync falls snap the counters to the generator's known positions.
  always_comb begin
    w_h_est = (r_h_cnt == H_LAST) ? 10'd0 : r_h_cnt + 10'd1;
    if (w_hs_fall) w_h_est = HS_START;
  end

  always_comb begin
    w_v_est = r_v_cnt;
    if (w_vs_fall) begin
      w_v_est = VS_START;
    end else if (w_h_est == 10'd0) begin
      w_v_est = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  assign w_err_h = (w_hs_fall && (r_h_cnt + 10'd1 != HS_START))
                 | (w_hs_rise && (w_h_est != HS_END));

  assign w_err_all = w_err_h
                   | (w_vs_fall && ((r_v_cnt != VS_PREV) || (w_h_est != 10'd0)))
                   | (w_vs_rise && ((w_v_est != VS_END) || (w_h_est != 10'd0)))
                   | (blank_n != ((w_h_est < H_ACT) && (w_v_est < V_ACT)));

  always_comb begin
    w_err = 1'b0;
    case (r_state)
      H_SEEN:         w_err = w_err_h;
      V_SEEN, LOCKED: w_err = w_err_all;
      default:        w_err = 1'b0;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else begin
      r_h_cnt <= w_h_est;
      r_v_cnt <= w_v_est;
    end
  end

  // An error outranks a vsync fall seen in the same cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state        <= SEARCH;
      r_good         <= '0;
      r_locked       <= 1'b0;
      r_timing_error <= 1'b0;
      r_err_count    <= 8'd0;
    end else begin
      r_timing_error <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_hs_fall) r_state <= H_SEEN;
        end
        H_SEEN: begin
          if (w_err) begin
            r_state <= SEARCH;
          end else if (w_vs_fall) begin
            r_state <= V_SEEN;
            r_good  <= '0;
          end
        end
        V_SEEN: begin
          if (w_err) begin
            r_state <= SEARCH;
          end else if (w_vs_fall) begin
            if (r_good == GOOD_LAST) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_err) begin
            r_state        <= SEARCH;
            r_locked       <= 1'b0;
            r_timing_error <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_pixel_x     <= 10'd0;
      r_pixel_y     <= 10'd0;
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_x     <= w_h_est;
      r_pixel_y     <= w_v_est;
      r_pixel_valid <= blank_n & r_locked;
      r_frame_start <= r_locked & (w_h_est == 10'd0) & (w_v_est == 10'd0);
    end
  end

  assign pixel_valid  = r_pixel_valid;
  assign pixel_x      = r_pixel_x;
  assign pixel_y      = r_pixel_y;
  assign frame_start  = r_frame_start;
  assign locked       = r_locked;
  assign timing_error = r_timing_error;
  assign err_count    = r_err_count;

endmodule
